gost89_ecb_arbiter: RTL

Shares one gost89_ecb core between two independent requesters. Arbitrates requests round-robin, latches the selected block and mode, and sequences the core's load/busy protocol. Returns the result on a common response channel tagged with the requester id. A watchdog aborts a hung core and reports an error.

---
 rtl/gost89_ecb_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/gost89_ecb_arbiter.sv
// Two-requester front end for a shared gost89_ecb core: round-robin grant,
// operand latching, load/busy sequencing, watchdog abort and tagged response.
module gost89_ecb_arbiter #(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req0_mode,
  input  logic [63:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_mode,
  input  logic [63:0]      req1_data,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [63:0]      rsp_data,
  output logic             rsp_err,
  input  logic             rsp_ready,
  output logic             core_load,
  output logic             core_reset,
  output logic             core_mode,
  output logic [63:0]      core_in,
  input  logic [63:0]      core_out,
  input  logic             core_busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_GUARD = 3'd2,
    S_WAIT  = 3'd3,
    S_ABORT = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               rr_q, rr_d;
  logic               id_q, id_d;
  logic               mode_q, mode_d;
  logic [DATA_W-1:0]  in_q, in_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               load_q, load_d;
  logic               creset_q, creset_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               grant_c;
  logic               any_req_c;

  // Round-robin pick: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    any_req_c = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_c = rr_q;
    end else begin
      grant_c = req1_valid;
    end
  end

  // State and datapath registers; reset holds the core in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      id_q        <= 1'b0;
      mode_q      <= 1'b0;
      in_q        <= '0;
      wd_q        <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      load_q      <= 1'b0;
      creset_q    <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      mode_q      <= mode_d;
      in_q        <= in_d;
      wd_q        <= wd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      load_q      <= load_d;
      creset_q    <= creset_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic; registered strobes are computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    mode_d      = mode_q;
    in_d        = in_q;
    wd_d        = wd_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = 1'b0;
    load_d      = 1'b0;
    creset_d    = 1'b0;
    cnt_d       = cnt_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          req0_ready = ~grant_c;
          req1_ready = grant_c;
          id_d       = grant_c;
          mode_d     = grant_c ? req1_mode : req0_mode;
          in_d       = grant_c ? req1_data : req0_data;
          rr_d       = ~grant_c;
          load_d     = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_GUARD;
      end
      S_GUARD: begin
        // Busy may not be asserted yet, so it is not looked at here.
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + WD_W'(1);
        if (!core_busy) begin
          rsp_data_d  = core_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          creset_d = 1'b1;
          state_d  = S_ABORT;
        end
      end
      S_ABORT: begin
        rsp_data_d  = '0;
        rsp_err_d   = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        if (rsp_ready) begin
          cnt_d       = cnt_q + CNT_W'(1);
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Core operands stay frozen from LOAD until the next accepted request.
  assign core_in    = in_q;
  assign core_mode  = mode_q;
  assign core_load  = load_q;
  assign core_reset = creset_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign op_count   = cnt_q;

endmodule
